// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage opcode/dest fields in, register controls out.
// FORWARD_EN adds the MEM/WB producer fields and the operand forwarding selects.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 3
);
  logic [3:0]       id_opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [3:0]       idex_opcode;
  logic [REG_W-1:0] idex_rd;
  logic [3:0]       exmem_opcode;
  logic [REG_W-1:0] exmem_rd;
  logic             exmem_zero;
  logic             mem_wait;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_write;
  logic             pc_redirect;
  logic             tmo_err;
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;
`ifdef FORWARD_EN
  logic [3:0]       memwb_opcode;
  logic [REG_W-1:0] memwb_rd;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
`endif

  modport master (
    output id_opcode, id_rs, id_rt, idex_opcode, idex_rd,
           exmem_opcode, exmem_rd, exmem_zero, mem_wait,
`ifdef FORWARD_EN
    output memwb_opcode, memwb_rd,
    input  fwd_a_sel, fwd_b_sel,
`endif
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
           exmem_write, pc_redirect, tmo_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_opcode, id_rs, id_rt, idex_opcode, idex_rd,
           exmem_opcode, exmem_rd, exmem_zero, mem_wait,
`ifdef FORWARD_EN
    input  memwb_opcode, memwb_rd,
    output fwd_a_sel, fwd_b_sel,
`endif
    output pc_write, ifid_write, ifid_flush, idex_bubble,
           exmem_write, pc_redirect, tmo_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW stalls, branch/jump redirect, mem-wait freeze.
// Optional macro FORWARD_EN: operand forwarding selects, only load-use stalls remain.
module pipeline_hazard_ctrl #(
  parameter int          REG_W   = 3,
  parameter logic [3:0]  OP_LOAD = 4'h8,
  parameter logic [3:0]  OP_BEQ  = 4'hA,
  parameter logic [3:0]  OP_JUMP = 4'hB,
  parameter logic [15:0] WB_MASK = 16'h01FF,
  parameter int          MEM_TMO = 255
) (
  input logic                   clock,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hif
);

  localparam int WAIT_W = $clog2(MEM_TMO + 1);
  localparam logic [WAIT_W-1:0] TMO_LIMIT = WAIT_W'(MEM_TMO);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} stateT;

  stateT             state;
  logic [WAIT_W-1:0] waitCnt;
  logic [15:0]       stallCnt;
  logic [15:0]       flushCnt;
  logic              tmoErr;

  logic redirectReq;
  logic rawHazard;
  logic evalRun;
  logic doRedirect;
  logic doStall;

  // Opcode 0 is the NOP that bubbles and flushes insert, so it never produces a value.
  function automatic logic isWriter(input logic [3:0] op, input logic [REG_W-1:0] rd);
    return WB_MASK[op] && (op != 4'h0) && (rd != '0);
  endfunction

  function automatic logic readsReg(input logic [REG_W-1:0] rd);
    return (hif.id_rs == rd) || (hif.id_rt == rd);
  endfunction

`ifdef FORWARD_EN
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (isWriter(hif.exmem_opcode, hif.exmem_rd) && hif.exmem_rd == src)
      sel = 2'd1;
    else if (isWriter(hif.memwb_opcode, hif.memwb_rd) && hif.memwb_rd == src)
      sel = 2'd2;
    return sel;
  endfunction

  assign hif.fwd_a_sel = fwdSel(hif.id_rs);
  assign hif.fwd_b_sel = fwdSel(hif.id_rt);
  assign rawHazard = isWriter(hif.idex_opcode, hif.idex_rd) &&
                     (hif.idex_opcode == OP_LOAD) && readsReg(hif.idex_rd);
`else
  assign rawHazard = (isWriter(hif.idex_opcode, hif.idex_rd) && readsReg(hif.idex_rd)) ||
                     (isWriter(hif.exmem_opcode, hif.exmem_rd) && readsReg(hif.exmem_rd));
`endif

  assign redirectReq = ((hif.exmem_opcode == OP_BEQ) && hif.exmem_zero) ||
                       (hif.exmem_opcode == OP_JUMP);
  // The HOLD release cycle is judged like RUN; FLUSH ignores both since its stages hold NOPs.
  assign evalRun    = (state != FLUSH) && !hif.mem_wait;
  assign doRedirect = evalRun && redirectReq;
  assign doStall    = evalRun && !redirectReq && rawHazard;

  always_comb begin
    hif.pc_write    = 1'b1;
    hif.ifid_write  = 1'b1;
    hif.exmem_write = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_bubble = 1'b0;
    hif.pc_redirect = 1'b0;
    if (reset) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.exmem_write = 1'b0;
      hif.ifid_flush  = 1'b1;
      hif.idex_bubble = 1'b1;
    end else if (hif.mem_wait) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.exmem_write = 1'b0;
    end else if (doRedirect) begin
      hif.pc_redirect = 1'b1;
      hif.ifid_flush  = 1'b1;
      hif.idex_bubble = 1'b1;
    end else if (doStall) begin
      hif.pc_write    = 1'b0;
      hif.ifid_write  = 1'b0;
      hif.idex_bubble = 1'b1;
    end
  end

  // The entry freeze cycle counts as the first mem-wait cycle toward the timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      waitCnt  <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
      tmoErr   <= 1'b0;
    end else if (hif.mem_wait) begin
      state <= HOLD;
      if (waitCnt != TMO_LIMIT) begin
        waitCnt <= waitCnt + 1'b1;
        if (waitCnt + 1'b1 == TMO_LIMIT)
          tmoErr <= 1'b1;
      end
    end else begin
      waitCnt <= '0;
      if (doRedirect) begin
        state <= FLUSH;
        if (flushCnt != 16'hFFFF)
          flushCnt <= flushCnt + 16'd1;
      end else begin
        state <= RUN;
        if (doStall && stallCnt != 16'hFFFF)
          stallCnt <= stallCnt + 16'd1;
      end
    end
  end

  assign hif.stall_cnt = stallCnt;
  assign hif.flush_cnt = flushCnt;
  assign hif.tmo_err   = tmoErr;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push expected controls,
// a negedge monitor pops and compares. Built with MEM_TMO=4 so the timeout is reachable.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] ADD  = 4'h1;
  localparam logic [3:0] LOAD = 4'h8;
  localparam logic [3:0] BEQ  = 4'hA;
  localparam logic [3:0] JMP  = 4'hB;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, pc_redirect}
  localparam logic [5:0] NORM   = 6'b110010;
  localparam logic [5:0] STALL  = 6'b000110;
  localparam logic [5:0] REDIR  = 6'b111111;
  localparam logic [5:0] FREEZE = 6'b000000;
  localparam logic [5:0] RSTV   = 6'b001100;

  typedef struct packed {
    int          vecId;
    logic [5:0]  ctrl;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
    logic        tmoErr;
  } expT;

  logic clock;
  logic reset;
  int   testsRun;
  int   testsFailed;
  int   vecNum;
  expT  expQ[$];

  pipeline_hazard_ctrl_if #(.REG_W(3)) hif ();

  pipeline_hazard_ctrl #(.REG_W(3), .MEM_TMO(4)) dut (
    .clock(clock),
    .reset(reset),
    .hif  (hif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input expT e);
    logic [5:0] gotCtrl;
    gotCtrl = {hif.pc_write, hif.ifid_write, hif.ifid_flush,
               hif.idex_bubble, hif.exmem_write, hif.pc_redirect};
    testsRun++;
    if (gotCtrl !== e.ctrl || hif.stall_cnt !== e.stallCnt ||
        hif.flush_cnt !== e.flushCnt || hif.tmo_err !== e.tmoErr) begin
      testsFailed++;
      $display("[TB] FAIL vec%0d: got ctrl=%b stall=%0d flush=%0d tmo=%b, expected ctrl=%b stall=%0d flush=%0d tmo=%b",
               e.vecId, gotCtrl, hif.stall_cnt, hif.flush_cnt, hif.tmo_err,
               e.ctrl, e.stallCnt, e.flushCnt, e.tmoErr);
    end
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0)
      checkOutput(expQ.pop_front());
  end

  // One vector per cycle; midRst asserts reset asynchronously partway through the cycle.
  task automatic applyStimulus(input logic rst, input logic midRst,
                               input logic [3:0] idOp, input logic [2:0] rs, input logic [2:0] rt,
                               input logic [3:0] idexOp, input logic [2:0] idexRd,
                               input logic [3:0] exOp, input logic [2:0] exRd,
                               input logic zero, input logic mw,
                               input logic [5:0] ctrl, input logic [15:0] sc,
                               input logic [15:0] fc, input logic tmo);
    expT e;
    @(posedge clock);
    #1;
    reset            = rst;
    hif.id_opcode    = idOp;
    hif.id_rs        = rs;
    hif.id_rt        = rt;
    hif.idex_opcode  = idexOp;
    hif.idex_rd      = idexRd;
    hif.exmem_opcode = exOp;
    hif.exmem_rd     = exRd;
    hif.exmem_zero   = zero;
    hif.mem_wait     = mw;
    if (midRst) begin
      #1;
      reset = 1'b1;
    end
    vecNum++;
    e.vecId    = vecNum;
    e.ctrl     = ctrl;
    e.stallCnt = sc;
    e.flushCnt = fc;
    e.tmoErr   = tmo;
    expQ.push_back(e);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    vecNum      = 0;
    reset       = 1'b1;
    hif.id_opcode = NOP; hif.id_rs = 0; hif.id_rt = 0;
    hif.idex_opcode = NOP; hif.idex_rd = 0;
    hif.exmem_opcode = NOP; hif.exmem_rd = 0;
    hif.exmem_zero = 0; hif.mem_wait = 0;

    //            rst mid idOp rs rt idexOp rd exOp rd z mw  ctrl   stl flu tmo
    applyStimulus(1, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 0, RSTV,   0, 0, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 0, NORM,   0, 0, 0);
    // back-to-back RAW: two bubbles, then free
    applyStimulus(0, 0, ADD, 3, 0, ADD, 3, NOP, 0, 0, 0, STALL,  0, 0, 0);
    applyStimulus(0, 0, ADD, 3, 0, NOP, 0, ADD, 3, 0, 0, STALL,  1, 0, 0);
    applyStimulus(0, 0, ADD, 3, 0, NOP, 0, NOP, 0, 0, 0, NORM,   2, 0, 0);
    // distance-2 producer on rt, R0 never hazards, non-writer never hazards
    applyStimulus(0, 0, ADD, 0, 5, NOP, 0, LOAD, 5, 0, 0, STALL, 2, 0, 0);
    applyStimulus(0, 0, ADD, 0, 0, ADD, 0, NOP, 0, 0, 0, NORM,   3, 0, 0);
    applyStimulus(0, 0, ADD, 3, 0, BEQ, 3, NOP, 0, 0, 0, NORM,   3, 0, 0);
    // taken branch beats pending RAW, FLUSH suppresses RAW, untaken branch ignored
    applyStimulus(0, 0, ADD, 4, 0, ADD, 4, BEQ, 0, 1, 0, REDIR,  3, 0, 0);
    applyStimulus(0, 0, ADD, 4, 0, ADD, 4, NOP, 0, 0, 0, NORM,   3, 1, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, BEQ, 0, 0, 0, NORM,   3, 1, 0);
    // jump frozen by 3 mem_wait cycles, redirect on release
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, JMP, 0, 0, 1, FREEZE, 3, 1, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, JMP, 0, 0, 1, FREEZE, 3, 1, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, JMP, 0, 0, 1, FREEZE, 3, 1, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, JMP, 0, 0, 0, REDIR,  3, 1, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 0, NORM,   3, 2, 0);
    // mem_wait for 6 cycles with MEM_TMO=4: flag rises at 4th HOLD cycle and sticks
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 1, FREEZE, 3, 2, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 1, FREEZE, 3, 2, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 1, FREEZE, 3, 2, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 1, FREEZE, 3, 2, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 1, FREEZE, 3, 2, 1);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 1, FREEZE, 3, 2, 1);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 0, NORM,   3, 2, 1);
    // async reset in the middle of a stall
    applyStimulus(0, 0, ADD, 3, 0, ADD, 3, NOP, 0, 0, 0, STALL,  3, 2, 1);
    applyStimulus(0, 1, ADD, 3, 0, ADD, 3, NOP, 0, 0, 0, RSTV,   0, 0, 0);
    applyStimulus(1, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 0, RSTV,   0, 0, 0);
    applyStimulus(0, 0, NOP, 0, 0, NOP, 0, NOP, 0, 0, 0, NORM,   0, 0, 0);

    repeat (3) @(posedge clock);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expected entries left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
